maq_moore_1101: RTL and testbench

//   Moore-type serial sequence detector for the bit pattern 1-1-0-1, with overlap allowed.
//   It samples one input bit per clock and raises a single-cycle output flag once the

---
 rtl/maq_moore_1101.sv | 49 ++++
 tb/tb_maq_moore_1101.sv | 124 ++++++++++++
 2 files changed

// File: rtl/maq_moore_1101.sv
`default_nettype none
// ============================================================================
// Module      : maq_moore_1101
// Description : Moore serial detector for the overlapping bit pattern 1101.
// Revision    : 1.0 - initial release
// ============================================================================
module maq_moore_1101 (
    input  logic clk,
    input  logic rst,
    input  logic input_bit,
    output logic output_bit
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = input_bit ? S1 : S0;
            S1:      w_next = input_bit ? S2 : S0;
            S2:      w_next = input_bit ? S2 : S3;
            S3:      w_next = input_bit ? S4 : S0;
            // Overlap: the trailing 1 of a match plus a new 1 is already "11"
            S4:      w_next = input_bit ? S2 : S0;
            default: w_next = S0;
        endcase
    end

    assign output_bit = (r_state == S4);

endmodule
`default_nettype wire

// File: tb/tb_maq_moore_1101.sv
`default_nettype none
// ============================================================================
// Module      : tb_maq_moore_1101
// Description : Directed self-checking bench for the 1101 Moore detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maq_moore_1101;

    logic clk;
    logic rst;
    logic input_bit;
    logic output_bit;

    int errors;
    int checks;

    maq_moore_1101 dut (
        .clk        (clk),
        .rst        (rst),
        .input_bit  (input_bit),
        .output_bit (output_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, check 1 ns after the following rising edge.
    task automatic step(input logic r, input logic b, input logic exp, input string tag);
        @(negedge clk);
        rst       = r;
        input_bit = b;
        @(posedge clk);
        #1;
        checks++;
        assert (output_bit === exp)
        else begin
            errors++;
            $error("FAIL %s: output_bit=%b expected=%b", tag, output_bit, exp);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        input_bit = 1'b0;

        // Reset, including reset winning over input_bit=1
        step(1'b1, 1'b0, 1'b0, "reset_x0");
        step(1'b1, 1'b1, 1'b0, "reset_x1");

        // Basic detect 1,1,0,1 then 0
        step(1'b0, 1'b1, 1'b0, "basic_b1");
        step(1'b0, 1'b1, 1'b0, "basic_b2");
        step(1'b0, 1'b0, 1'b0, "basic_b3");
        step(1'b0, 1'b1, 1'b1, "basic_b4");
        step(1'b0, 1'b0, 1'b0, "basic_after");

        // Mixed stream 1,1,0,1,0,0,1,1,0,1,0,1
        step(1'b1, 1'b0, 1'b0, "mixed_rst");
        step(1'b0, 1'b1, 1'b0, "mixed_1");
        step(1'b0, 1'b1, 1'b0, "mixed_2");
        step(1'b0, 1'b0, 1'b0, "mixed_3");
        step(1'b0, 1'b1, 1'b1, "mixed_4");
        step(1'b0, 1'b0, 1'b0, "mixed_5");
        step(1'b0, 1'b0, 1'b0, "mixed_6");
        step(1'b0, 1'b1, 1'b0, "mixed_7");
        step(1'b0, 1'b1, 1'b0, "mixed_8");
        step(1'b0, 1'b0, 1'b0, "mixed_9");
        step(1'b0, 1'b1, 1'b1, "mixed_10");
        step(1'b0, 1'b0, 1'b0, "mixed_11");
        step(1'b0, 1'b1, 1'b0, "mixed_12");

        // Overlap 1,1,0,1,1,0,1
        step(1'b1, 1'b0, 1'b0, "ovl_rst");
        step(1'b0, 1'b1, 1'b0, "ovl_1");
        step(1'b0, 1'b1, 1'b0, "ovl_2");
        step(1'b0, 1'b0, 1'b0, "ovl_3");
        step(1'b0, 1'b1, 1'b1, "ovl_4");
        step(1'b0, 1'b1, 1'b0, "ovl_5");
        step(1'b0, 1'b0, 1'b0, "ovl_6");
        step(1'b0, 1'b1, 1'b1, "ovl_7");
        // Reset from the detect state with input_bit=1
        step(1'b1, 1'b1, 1'b0, "ovl_rst_from_s4");

        // Long run of 1s then 0,1
        step(1'b1, 1'b0, 1'b0, "run_rst");
        step(1'b0, 1'b1, 1'b0, "run_1");
        step(1'b0, 1'b1, 1'b0, "run_2");
        step(1'b0, 1'b1, 1'b0, "run_3");
        step(1'b0, 1'b1, 1'b0, "run_4");
        step(1'b0, 1'b1, 1'b0, "run_5");
        step(1'b0, 1'b0, 1'b0, "run_6");
        step(1'b0, 1'b1, 1'b1, "run_7");

        // Mid-sequence reset: 1,1,0, rst, 1 -> S1; then 1,0,1 proves S1 via a pulse
        step(1'b1, 1'b0, 1'b0, "mid_rst0");
        step(1'b0, 1'b1, 1'b0, "mid_1");
        step(1'b0, 1'b1, 1'b0, "mid_2");
        step(1'b0, 1'b0, 1'b0, "mid_3");
        step(1'b1, 1'b1, 1'b0, "mid_rst");
        step(1'b0, 1'b1, 1'b0, "mid_s1");
        step(1'b0, 1'b1, 1'b0, "mid_s2");
        step(1'b0, 1'b0, 1'b0, "mid_s3");
        step(1'b0, 1'b1, 1'b1, "mid_s4");

        // Near misses 1,0,1,1 and 0,1,0,1
        step(1'b1, 1'b0, 1'b0, "nm_rst_a");
        step(1'b0, 1'b1, 1'b0, "nm_a1");
        step(1'b0, 1'b0, 1'b0, "nm_a2");
        step(1'b0, 1'b1, 1'b0, "nm_a3");
        step(1'b0, 1'b1, 1'b0, "nm_a4");
        step(1'b1, 1'b0, 1'b0, "nm_rst_b");
        step(1'b0, 1'b0, 1'b0, "nm_b1");
        step(1'b0, 1'b1, 1'b0, "nm_b2");
        step(1'b0, 1'b0, 1'b0, "nm_b3");
        step(1'b0, 1'b1, 1'b0, "nm_b4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
